// File: rtl/pa_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// pa_fifo_wr_arbiter: round-robin, burst-locked sharing of one PA_fifo write port among NUM_REQ producers.
// Latency: 1-cycle arbitration bubble leaving IDLE; while locked, beats pass through combinationally to the FIFO.
// Backpressure: i_fifo_full drops the owner's ready. The owner keeps its grant through any stall.
// Optional: define PA_ARB_STALL_CNT_EN to build the saturating full-stall counter behind o_stall_cnt.
module pa_fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic                           i_fifo_full,
  output logic                           o_fifo_wr_en,
  output logic [SIZE_DATA-1:0]           o_fifo_data,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic [15:0]                    o_stall_cnt
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     rr_ptr;
  logic [7:0]           beat_cnt;

  logic                 owner_vld;
  logic                 accept;
  logic                 last_beat;
  logic                 release_burst;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     arb_base;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [SIZE_DATA-1:0] owner_data;
  logic [NUM_REQ-1:0]   ready;

  // Owner handshake and release decision; grant is zero in IDLE so nothing is ready there.
  always_comb begin
    ready         = grant & {NUM_REQ{~i_fifo_full}};
    owner_vld     = |(i_req_valid & grant);
    accept        = |(i_req_valid & ready);
    last_beat     = (beat_cnt == 8'(MAX_BURST - 1));
    release_burst = (state == LOCK) && ((accept && last_beat) || !owner_vld);
    next_ptr      = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    arb_base      = (state == LOCK) ? next_ptr : rr_ptr;
  end

  // Round-robin search: first valid requester at or after arb_base, wrapping; the old owner ends up last.
  always_comb begin
    logic [IDX_W:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, arb_base} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && i_req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Owner data select; grant is one-hot, so at most one slice is picked.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) owner_data = i_req_data[k*SIZE_DATA +: SIZE_DATA];
    end
  end

  assign o_req_ready  = ready;
  assign o_fifo_wr_en = accept;
  assign o_fifo_data  = accept ? owner_data : '0;
  assign o_grant      = grant;
  assign o_busy       = (state == LOCK);

  // Arbitration FSM: IDLE picks from rr_ptr; LOCK counts beats and re-arbitrates without a bubble on release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= LOCK;
            grant    <= NUM_REQ'(1) << win_idx;
            owner    <= win_idx;
            beat_cnt <= '0;
          end
        end
        LOCK: begin
          if (release_burst) begin
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
            if (win_found) begin
              grant <= NUM_REQ'(1) << win_idx;
              owner <= win_idx;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef PA_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Saturating count of cycles where the owner has data but the FIFO is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if ((state == LOCK) && owner_vld && i_fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pa_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// tb_pa_fifo_wr_arbiter: directed scenarios plus a randomized producer/FIFO scoreboard for the write-port arbiter.
module tb_pa_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data;
  logic [NR-1:0]    grant;
  logic             busy;
  logic [15:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  pa_fifo_wr_arbiter #(.NUM_REQ(NR), .SIZE_DATA(DW), .MAX_BURST(MB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_fifo_full  (fifo_full),
    .o_fifo_wr_en (fifo_wr_en),
    .o_fifo_data  (fifo_data),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hFFFF_FFFF;
    fifo_full = 1'b0;
    #2;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", fifo_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall got %h exp 0000", stall_cnt); end
    do_reset();
  endtask

  task automatic test_single_burst();
    do_reset();
    tick();
    req_valid = 4'b0001;
    req_data[7:0] = 8'h10;
    settle();
    checks++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL t1_bubble got grant %b wr %b exp 0000 0", grant, fifo_wr_en); end
    for (int b = 0; b < 6; b++) begin
      tick();
      req_data[7:0] = 8'h10 + 8'(b);
      settle();
      checks++;
      if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_data !== 8'h10 + 8'(b))
        begin errors++; $display("FAIL t1_beat%0d got grant %b wr %b data %h exp 0001 1 %h", b, grant, fifo_wr_en, fifo_data, 8'h10 + 8'(b)); end
    end
    tick();
    req_valid = 4'b0000;
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0001) begin errors++; $display("FAIL t1_drop got wr %b grant %b exp 0 0001", fifo_wr_en, grant); end
    tick();
    settle();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL t1_idle got grant %b busy %b exp 0000 0", grant, busy); end
  endtask

  task automatic test_round_robin();
    int exp_o;
    do_reset();
    tick();
    req_valid = 4'b1111;
    req_data  = 32'hA3A2_A1A0;
    settle();
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL t2_bubble got wr %b exp 0", fifo_wr_en); end
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      exp_o = (i / 4) % 4;
      checks++;
      if (grant !== 4'(1 << exp_o) || fifo_wr_en !== 1'b1 || fifo_data !== 8'hA0 + 8'(exp_o))
        begin errors++; $display("FAIL t2_cycle%0d got grant %b wr %b data %h exp owner %0d", i, grant, fifo_wr_en, fifo_data, exp_o); end
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    logic [15:0] exp_stall;
`ifdef PA_ARB_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    tick();
    req_valid = 4'b0110;
    req_data  = 32'h0032_3100;
    settle();
    for (int b = 0; b < 2; b++) begin
      tick();
      settle();
      checks++; if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data !== 8'h31) begin errors++; $display("FAIL t3_pre%0d got grant %b wr %b data %h exp 0010 1 31", b, grant, fifo_wr_en, fifo_data); end
    end
    for (int s = 0; s < 5; s++) begin
      tick();
      fifo_full = 1'b1;
      settle();
      checks++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL t3_stall%0d got ready %b wr %b grant %b exp 0000 0 0010", s, req_ready, fifo_wr_en, grant); end
    end
    for (int b = 0; b < 2; b++) begin
      tick();
      fifo_full = 1'b0;
      settle();
      checks++; if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data !== 8'h31) begin errors++; $display("FAIL t3_post%0d got grant %b wr %b data %h exp 0010 1 31", b, grant, fifo_wr_en, fifo_data); end
    end
    tick();
    settle();
    checks++; if (grant !== 4'b0100 || fifo_data !== 8'h32) begin errors++; $display("FAIL t3_rotate got grant %b data %h exp 0100 32", grant, fifo_data); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL t3_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_early_drop();
    int wr2;
    wr2 = 0;
    do_reset();
    tick();
    req_valid = 4'b1100;
    req_data  = 32'h4342_0000;
    settle();
    for (int b = 0; b < 2; b++) begin
      tick();
      settle();
      if (fifo_wr_en === 1'b1 && grant === 4'b0100) wr2++;
    end
    tick();
    req_valid = 4'b1000;
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0100) begin errors++; $display("FAIL t4_drop got wr %b grant %b exp 0 0100", fifo_wr_en, grant); end
    tick();
    settle();
    checks++; if (grant !== 4'b1000 || fifo_wr_en !== 1'b1 || fifo_data !== 8'h43) begin errors++; $display("FAIL t4_next got grant %b wr %b data %h exp 1000 1 43", grant, fifo_wr_en, fifo_data); end
    checks++; if (wr2 !== 2) begin errors++; $display("FAIL t4_req2_writes got %0d exp 2", wr2); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tick();
    req_valid = 4'b0011;
    req_data  = 32'h0000_5150;
    settle();
    for (int b = 0; b < 6; b++) begin
      tick();
      settle();
      checks++;
      if (grant !== ((b < 4) ? 4'b0001 : 4'b0010) || fifo_wr_en !== 1'b1 || fifo_data !== ((b < 4) ? 8'h50 : 8'h51))
        begin errors++; $display("FAIL t5_beat%0d got grant %b wr %b data %h", b, grant, fifo_wr_en, fifo_data); end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL t5_async got grant %b ready %b wr %b exp zeros", grant, req_ready, fifo_wr_en); end
    tick();
    settle();
    checks++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_held got wr %b busy %b exp 0 0", fifo_wr_en, busy); end
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    settle();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t5_bubble got grant %b exp 0000", grant); end
    tick();
    settle();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_regrant got grant %b exp 0001", grant); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [7:0]    exp_q[$];
    logic [7:0]    fq[$];
    logic [NR-1:0] pend;
    logic [7:0]    pdat[NR];
    int            waitb[NR];
    logic [7:0]    seq;
    logic [NR-1:0] acc;
    logic [7:0]    rd;
    logic [7:0]    ex;
    pend = '0;
    seq  = 8'h00;
    for (int j = 0; j < NR; j++) begin pdat[j] = '0; waitb[j] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      fifo_full = (fq.size() >= 8);
      for (int j = 0; j < NR; j++) begin
        if (!pend[j] && $urandom_range(0, 1) == 1) begin
          pend[j]  = 1'b1;
          pdat[j]  = seq;
          seq      = seq + 8'd1;
          waitb[j] = 0;
        end
        req_data[j*DW +: DW] = pdat[j];
      end
      req_valid = pend;
      settle();
      checks++; if (fifo_wr_en && fifo_full) begin errors++; $display("FAIL rnd_wr_full cycle %0d got wr 1 with full 1 exp wr 0", cyc); end
      acc = req_valid & req_ready;
      checks++;
      if (fifo_wr_en !== (|acc) || $countones(acc) > 1)
        begin errors++; $display("FAIL rnd_handshake cycle %0d got wr %b ready %b valid %b", cyc, fifo_wr_en, req_ready, req_valid); end
      for (int j = 0; j < NR; j++) begin
        if (acc[j]) begin
          exp_q.push_back(pdat[j]);
          checks++; if (waitb[j] > (NR - 1) * MB) begin errors++; $display("FAIL rnd_starve req%0d got %0d beats waited exp <= %0d", j, waitb[j], (NR - 1) * MB); end
          pend[j] = 1'b0;
          for (int m = 0; m < NR; m++) if (m != j && pend[m]) waitb[m]++;
        end
      end
      if (fq.size() > 0 && $urandom_range(0, 9) < 6) begin
        rd = fq.pop_front();
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_order cycle %0d got %h exp %h", cyc, rd, ex); end
      end
      if (fifo_wr_en === 1'b1) fq.push_back(fifo_data);
    end
    tick();
    req_valid = '0;
    fifo_full = 1'b0;
    for (int d = 0; d < 40 && fq.size() > 0; d++) begin
      rd = fq.pop_front();
      ex = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_drain got %h exp %h", rd, ex); end
    end
    checks++; if (fq.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got fifo %0d expected-queue %0d exp 0 0", fq.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
